xor_crc_unit: RTL and testbench
===============================

Name: xor_crc_unit

Overview:
- Parametrised successor to the single-bit XOR gate. An XOR-tree CRC/LFSR engine that folds a stream of DATA_W-bit words into a CRC_W-bit checksum over framed packets.
- Sits between a byte/word source and a framing or checking stage.
- Valid/ready handshake on both sides; one result per frame, held until consumed.

Parameters:
- CRC_W, 8, checksum width in bits (2..32).
- DATA_W, 8, input word width in bits (1..64).
- POLY, 8'h07, generator polynomial, implicit top bit, width CRC_W.
- INIT, 0, CRC register value at reset and at the start of each frame, width CRC_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_W  data word, processed MSB first.
- in_last  input  1  final word of the frame.
- out_valid  output  1  out_crc holds a completed frame CRC.
- out_ready  input  1  downstream consumes the result.
- out_crc  output  CRC_W  registered CRC of the last completed frame.

Behaviour:
- Reset values (async, rst=1): state=IDLE, crc_reg=INIT, out_crc=0, out_valid=0. in_ready=1 once rst deasserts.
- Accept: a beat transfers when in_valid & in_ready are high at the clk edge.
- Update rule: next = crc_reg XORed bit-serially with in_data, unrolled DATA_W steps within one cycle. Each step, with b = current in_data bit (MSB first):
  - fb = crc[CRC_W-1] ^ b
  - crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0)
- No reflection, no final XOR.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1.
    - Accepted beat with in_last=0 -> crc_reg=next, go to ACCUM.
    - Accepted beat with in_last=1 -> out_crc=next, out_valid=1, crc_reg=INIT, go to HOLD.
  - ACCUM: in_ready=1. Same transitions as IDLE. No beat -> stay, crc_reg unchanged.
  - HOLD: in_ready=0, out_crc stable, out_valid=1.
    - out_valid & out_ready -> out_valid=0, go to IDLE.
    - No bypass: in_ready rises the cycle after the output handshake.
- Latency: out_valid rises on the edge that accepts the in_last beat, i.e. the result is visible the cycle after the last beat was presented.
- Throughput: one word per cycle within a frame. One bubble cycle minimum between frames (the HOLD cycle).
- Single-word frames are legal.
- in_valid=0 gaps mid-frame are legal; state is preserved.
- in_data/in_last are ignored whenever in_ready=0.
- out_ready is ignored while out_valid=0.
- rst asserted mid-frame or in HOLD: the partial CRC and any pending result are discarded; all registers return to reset values.

Optional Feature:
- Macro: XOR_CRC_CHECK_EN.
- When defined, adds port out_err (output, 1 bit, reset 0):
  - Registered alongside out_crc: out_err = (next != 0) on the in_last beat.
  - Purpose: receive-side residue check, where the frame carries its CRC appended MSB-first.
  - out_err is valid while out_valid=1 and is cleared together with out_valid.
- When undefined: no out_err port, no comparator logic; behaviour otherwise identical.

Test Plan:
- Reset with in_valid=1, then release -> out_valid=0, out_crc=0x00 during reset; in_ready=1 one cycle after release; nothing accepted while rst=1.
- Defaults, single frame 0x01 (in_last=1) -> out_valid=1 next cycle, out_crc=0x07.
- Frame 0x01,0x00 -> out_crc=0x15.
- Frame "123456789" (0x31..0x39) with random in_valid gaps -> out_crc=0xF4.
- Hold out_ready=0 for 5 cycles after a result -> in_ready=0 and out_crc stable throughout; after one out_ready pulse, out_valid=0 and in_ready=1 on the next cycle.
- Assert rst after 4 of 9 bytes of "123456789", then send the full frame -> out_crc=0xF4 (no contamination).
- With XOR_CRC_CHECK_EN:
  - "123456789" followed by 0xF4 as the last beat -> out_crc=0x00, out_err=0.
  - Same frame with last beat 0xF5 -> out_err=1.

Source files
------------

// File: rtl/xor_crc_unit.sv
// xor_crc_unit: XOR-tree CRC/LFSR engine folding DATA_W-bit words into a
// CRC_W-bit checksum over framed packets. One result per frame, held in
// out_crc until the downstream side consumes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Upstream may not withdraw nothing here depends on that;
// in_data/in_last are ignored while in_ready=0 and out_ready is ignored
// while out_valid=0.
//
// Optional feature: define XOR_CRC_CHECK_EN to add the out_err port, a
// receive-side residue check (out_err=1 when the frame CRC is non-zero).
module xor_crc_unit #(
    parameter int                unsigned CRC_W  = 8,
    parameter int                unsigned DATA_W = 8,
    parameter logic [CRC_W-1:0]  POLY   = 8'h07,
    parameter logic [CRC_W-1:0]  INIT   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef XOR_CRC_CHECK_EN
    output logic              out_err,
`endif
    output logic [CRC_W-1:0]  out_crc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Kept as a named internal signal so checkers can bind to the FSM state.
    state_t state;
    state_t next_state;

    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_next;
    logic             beat;
    logic             out_valid_r;

    // One full word folded bit-serially, MSB first, unrolled into one cycle.
    function automatic logic [CRC_W-1:0] crc_fold(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] data_in
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_in[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // Ready is held low during reset so nothing is taken while rst=1.
    assign in_ready  = ~rst && (state != HOLD);
    assign beat      = in_valid && in_ready;
    assign crc_next  = crc_fold(crc_reg, in_data);
    assign out_valid = out_valid_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE and ACCUM share transitions; HOLD waits for consume.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    next_state = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_valid_r && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Running CRC: advance on mid-frame beats, re-seed when a frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= INIT;
        end else if (beat) begin
            crc_reg <= in_last ? INIT : crc_next;
        end
    end

    // Result register: captured on the last beat and held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_crc     <= '0;
            out_valid_r <= 1'b0;
        end else if (beat && in_last) begin
            out_crc     <= crc_next;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef XOR_CRC_CHECK_EN
    // Residue flag travels with out_crc and clears together with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err <= 1'b0;
        end else if (beat && in_last) begin
            out_err <= (crc_next != '0);
        end else if (out_valid_r && out_ready) begin
            out_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_xor_crc_unit.sv
module tb_xor_crc_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_crc;
`ifdef XOR_CRC_CHECK_EN
    logic       out_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] frame[$];

    xor_crc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef XOR_CRC_CHECK_EN
        .out_err   (out_err),
`endif
        .out_crc   (out_crc)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1, done as
    // textbook long division over the message bit string (INIT is zero).
    function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
        bit      bits[$];
        int      rem;
        foreach (msg[k]) begin
            for (int j = 7; j >= 0; j--) bits.push_back(msg[k][j]);
        end
        for (int j = 0; j < 8; j++) bits.push_back(1'b0);
        rem = 0;
        foreach (bits[k]) begin
            rem = (rem << 1) | int'(bits[k]);
            if (rem >= 256) rem = rem ^ 32'h107;
        end
        return rem[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat; waits (bounded) for in_ready, returns after acceptance.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
        in_last  = $urandom_range(0, 1);
    endtask

    // Send the whole frame queue, optionally with random idle gaps.
    task automatic send_frame(input bit gaps);
        for (int k = 0; k < frame.size(); k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int i = 0; i < g; i++) tick();
            end
            send_beat(frame[k], k == frame.size() - 1);
        end
    endtask

    // Compare the held result against the scoreboard, then consume it.
    task automatic check_and_consume(input string tag);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_crc"}, out_crc, exp);
`ifdef XOR_CRC_CHECK_EN
        check({tag, "_err"}, out_err, exp != 8'h00);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_cleared"}, out_valid, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic load_check_string();
        frame.delete();
        for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        logic [7:0] held;

        // Reset with in_valid asserted: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_last   = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_crc", out_crc, 8'h00);
`ifdef XOR_CRC_CHECK_EN
        check("rst_out_err", out_err, 1'b0);
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

        // Single word frame 0x01.
        frame = '{8'h01};
        exp_q.push_back(8'h07);
        check("model_01", crc_model(frame), 8'h07);
        send_frame(1'b0);
        check_and_consume("f01");

        // Frame 0x01,0x00.
        frame = '{8'h01, 8'h00};
        exp_q.push_back(8'h15);
        check("model_0100", crc_model(frame), 8'h15);
        send_frame(1'b0);
        check_and_consume("f0100");

        // "123456789" with random gaps.
        load_check_string();
        exp_q.push_back(8'hF4);
        check("model_check", crc_model(frame), 8'hF4);
        send_frame(1'b1);
        check_and_consume("fcheck");

        // Hold the result: junk on the input must be ignored.
        frame = '{8'hA5, 8'h3C};
        exp_q.push_back(crc_model(frame));
        send_frame(1'b0);
        held = out_crc;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom_range(0, 255);
            in_last  = 1'b1;
            tick();
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_stable", out_crc, held);
            check("hold_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        check_and_consume("fhold");

        // Reset mid-frame after 4 of 9 bytes, then a clean full frame.
        load_check_string();
        for (int k = 0; k < 4; k++) send_beat(frame[k], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_crc", out_crc, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(8'hF4);
        send_frame(1'b1);
        check_and_consume("fafter_rst");

        // Reset while a result is held discards it.
        frame = '{8'h42};
        send_frame(1'b0);
        #2 rst = 1'b1;
        #1;
        check("holdrst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("holdrst_in_ready", in_ready, 1'b1);

`ifdef XOR_CRC_CHECK_EN
        // Residue check: appended correct CRC gives zero, wrong one flags.
        load_check_string();
        frame.push_back(8'hF4);
        exp_q.push_back(8'h00);
        send_frame(1'b1);
        check_and_consume("resid_ok");
        load_check_string();
        frame.push_back(8'hF5);
        exp_q.push_back(crc_model(frame));
        send_frame(1'b1);
        check("resid_bad_err", out_err, 1'b1);
        check_and_consume("resid_bad");
`endif

        // Random frames against the model.
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 7);
            frame.delete();
            for (int k = 0; k < len; k++) frame.push_back(8'($urandom_range(0, 255)));
            exp_q.push_back(crc_model(frame));
            send_frame(1'b1);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("rand_wait_valid", out_valid, 1'b1);
            end
            check_and_consume("rand");
        end

        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
